// File: rtl/spi_reg_bank.sv
// SPI-loaded bank of NREGS x DATA_W configuration registers, SCLK/CSB/MOSI oversampled in i_clk.
// Define REGBANK_SHADOW_EN to stage writes in a shadow bank that is copied to o_regs on i_commit.
module spi_reg_bank #(
    parameter int NREGS       = 8,
    parameter int DATA_W      = 24,
    parameter int SYNC_STAGES = 2,
    parameter logic [NREGS*DATA_W-1:0] RESET_VAL = '0,
    localparam int ADDR_W     = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic                    i_clk,
    input  logic                    i_reset_n,
    input  logic                    i_csb,
    input  logic                    i_sclk,
    input  logic                    i_mosi,
    input  logic                    i_lock,
    input  logic                    i_commit,
    output logic [NREGS*DATA_W-1:0] o_regs,
    output logic                    o_wr_pulse,
    output logic [ADDR_W-1:0]       o_wr_addr,
    output logic                    o_err
);

    localparam int FRAME_W = ADDR_W + DATA_W;
    localparam int CNT_W   = $clog2(FRAME_W + 2);

    typedef enum logic [1:0] {
        WAIT_HIGH,
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t state;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] csb_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_d;
    logic                   csb_d;
    logic                   sclk_s;
    logic                   csb_s;
    logic                   mosi_s;
    logic                   sclk_rise;
    logic                   csb_fall;
    logic                   csb_rise;

    // CSB chain resets low so WAIT_HIGH only leaves once the pad is really seen high.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            sclk_sync <= '0;
            csb_sync  <= '0;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
            csb_d     <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], i_sclk};
            csb_sync  <= {csb_sync[SYNC_STAGES-2:0], i_csb};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], i_mosi};
            sclk_d    <= sclk_s;
            csb_d     <= csb_s;
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign csb_s     = csb_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign csb_fall  = ~csb_s & csb_d;
    assign csb_rise  = csb_s & ~csb_d;

    logic [FRAME_W-1:0] shifter;
    logic [CNT_W-1:0]   bit_cnt;
    logic [ADDR_W-1:0]  frame_addr;
    logic [DATA_W-1:0]  frame_data;
    logic               len_ok;
    logic               addr_ok;
    logic               wr_en;
    logic               err_en;

    assign frame_addr = shifter[FRAME_W-1 -: ADDR_W];
    assign frame_data = shifter[DATA_W-1:0];
    assign len_ok     = (bit_cnt == CNT_W'(FRAME_W));

    generate
        if (NREGS == (1 << ADDR_W)) begin : g_addr_full
            assign addr_ok = 1'b1;
        end else begin : g_addr_cmp
            assign addr_ok = (frame_addr < ADDR_W'(NREGS));
        end
    endgenerate

    // Malformed frames are flagged even while locked; well-formed locked frames vanish silently.
    assign wr_en  = (state == DONE) && len_ok && addr_ok && !i_lock;
    assign err_en = (state == DONE) && !(len_ok && addr_ok);

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state      <= WAIT_HIGH;
            shifter    <= '0;
            bit_cnt    <= '0;
            o_wr_pulse <= 1'b0;
            o_err      <= 1'b0;
            o_wr_addr  <= '0;
        end else begin
            o_wr_pulse <= wr_en;
            o_err      <= err_en;
            if (wr_en) begin
                o_wr_addr <= frame_addr;
            end
            case (state)
                WAIT_HIGH: begin
                    if (csb_s) begin
                        state <= IDLE;
                    end
                end
                IDLE: begin
                    if (csb_fall) begin
                        shifter <= '0;
                        bit_cnt <= '0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (sclk_rise) begin
                        shifter <= {shifter[FRAME_W-2:0], mosi_s};
                        if (bit_cnt != CNT_W'(FRAME_W + 1)) begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                    if (csb_rise) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= WAIT_HIGH;
                end
            endcase
        end
    end

    logic [NREGS*DATA_W-1:0] bank_cur;
    logic [NREGS*DATA_W-1:0] bank_next;

`ifdef REGBANK_SHADOW_EN
    logic [NREGS*DATA_W-1:0] shadow_q;
    assign bank_cur = shadow_q;
`else
    logic unused_commit;
    assign unused_commit = i_commit;
    assign bank_cur      = o_regs;
`endif

    always_comb begin
        bank_next = bank_cur;
        for (int k = 0; k < NREGS; k++) begin
            if (wr_en && (frame_addr == ADDR_W'(k))) begin
                bank_next[k*DATA_W +: DATA_W] = frame_data;
            end
        end
    end

    // A commit in the write cycle copies bank_next, so the coinciding write is included.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            o_regs   <= RESET_VAL;
`ifdef REGBANK_SHADOW_EN
            shadow_q <= RESET_VAL;
`endif
        end else begin
`ifdef REGBANK_SHADOW_EN
            shadow_q <= bank_next;
            if (i_commit) begin
                o_regs <= bank_next;
            end
`else
            o_regs   <= bank_next;
`endif
        end
    end

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed bench for spi_reg_bank: an 8-register and a 6-register instance share one SPI bus,
// so each frame is checked against both address ranges.
module tb_spi_reg_bank;

    localparam int DW   = 24;
    localparam int AW   = 3;
    localparam int HALF = 6;
    localparam logic [8*DW-1:0] RV8 = {24'h700007, 24'h600006, 24'h500005, 24'h400004,
                                       24'h300003, 24'h200002, 24'h100001, 24'h0A0A0A};
`ifdef REGBANK_SHADOW_EN
    localparam logic COMMIT_DEF = 1'b1;
`else
    localparam logic COMMIT_DEF = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset_n;
    logic            csb;
    logic            sclk;
    logic            mosi;
    logic            lock;
    logic            commit;
    logic [8*DW-1:0] regs8;
    logic [6*DW-1:0] regs6;
    logic            wr8, wr6, err8, err6;
    logic [AW-1:0]   wa8, wa6;

    spi_reg_bank #(.NREGS(8), .DATA_W(DW), .SYNC_STAGES(2), .RESET_VAL(RV8)) dut (
        .i_clk(clk), .i_reset_n(reset_n), .i_csb(csb), .i_sclk(sclk), .i_mosi(mosi),
        .i_lock(lock), .i_commit(commit), .o_regs(regs8), .o_wr_pulse(wr8),
        .o_wr_addr(wa8), .o_err(err8)
    );

    spi_reg_bank #(.NREGS(6), .DATA_W(DW), .SYNC_STAGES(2)) dut6 (
        .i_clk(clk), .i_reset_n(reset_n), .i_csb(csb), .i_sclk(sclk), .i_mosi(mosi),
        .i_lock(lock), .i_commit(commit), .o_regs(regs6), .o_wr_pulse(wr6),
        .o_wr_addr(wa6), .o_err(err6)
    );

    // clock / reset
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, exp);
        end
    endtask

    // scoreboard: register models, expected write addresses, pulse counts
    logic [DW-1:0] m8[8];
    logic [DW-1:0] m6[6];
    logic [AW-1:0] exp_q[$];
    int n_wr8 = 0, n_err8 = 0, n_wr6 = 0, n_err6 = 0;
    int e_wr8 = 0, e_err8 = 0, e_wr6 = 0, e_err6 = 0;

    function automatic logic [8*DW-1:0] pack8();
        logic [8*DW-1:0] r;
        for (int k = 0; k < 8; k++) r[k*DW +: DW] = m8[k];
        return r;
    endfunction

    function automatic logic [6*DW-1:0] pack6();
        logic [6*DW-1:0] r;
        for (int k = 0; k < 6; k++) r[k*DW +: DW] = m6[k];
        return r;
    endfunction

    always @(negedge clk) begin
        if (wr8) begin
            if (exp_q.size() == 0) check("wr8_unexpected", 192'(wr8), 192'(0));
            else check("wr8_addr", 192'(wa8), 192'(exp_q.pop_front()));
            n_wr8++;
        end
        if (err8) n_err8++;
        if (wr6)  n_wr6++;
        if (err6) n_err6++;
    end

    task automatic check_all(input string tag);
        check({tag, "_regs8"}, regs8, pack8());
        check({tag, "_regs6"}, 192'(regs6), 192'(pack6()));
        check({tag, "_wr8"},  192'(n_wr8),  192'(e_wr8));
        check({tag, "_err8"}, 192'(n_err8), 192'(e_err8));
        check({tag, "_wr6"},  192'(n_wr6),  192'(e_wr6));
        check({tag, "_err6"}, 192'(n_err6), 192'(e_err6));
    endtask

    // drivers
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic spi_bits(input logic [63:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            mosi = bits[i];
            tick(HALF);
            sclk = 1'b1;
            tick(HALF);
            sclk = 1'b0;
        end
    endtask

    task automatic frame_begin();
        csb = 1'b0;
        tick(HALF);
    endtask

    task automatic frame_end();
        tick(HALF);
        csb = 1'b1;
        tick(12);
    endtask

    task automatic send_frame(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        logic [63:0] bits;
        bits = 64'({addr, data});
        frame_begin();
        spi_bits(bits, AW + DW);
        frame_end();
    endtask

    task automatic expect_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        exp_q.push_back(addr);
        e_wr8++;
        m8[addr] = data;
        if (addr < 6) begin
            e_wr6++;
            m6[addr] = data;
        end else begin
            e_err6++;
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 8; k++) m8[k] = RV8[k*DW +: DW];
        for (int k = 0; k < 6; k++) m6[k] = '0;
    endtask

    initial begin
        logic [63:0] bits;
        csb = 1'b1; sclk = 1'b0; mosi = 1'b0; lock = 1'b0; commit = COMMIT_DEF;
        reset_n = 1'b0;
        model_reset();
        tick(3);
        reset_n = 1'b1;
        tick(8);
        check_all("reset");
        check("reset_waddr", 192'(wa8), 192'(0));
        check("reset_pulses", 192'({wr8, err8, wr6, err6}), 192'(0));

        expect_write(3'd3, 24'hABCDEF);
        send_frame(3'd3, 24'hABCDEF);
        check_all("wr3");
        check("wr3_waddr8", 192'(wa8), 192'(3));
        check("wr3_waddr6", 192'(wa6), 192'(3));

        // 26-bit then 28-bit frames
        frame_begin(); spi_bits(64'h2AAAAAA, 26); frame_end();
        frame_begin(); spi_bits(64'hFFFFFFF, 28); frame_end();
        e_err8 += 2; e_err6 += 2;
        check_all("badlen");

        expect_write(3'd6, 24'h000055);
        send_frame(3'd6, 24'h000055);
        check_all("addr6");
        check("addr6_waddr6_held", 192'(wa6), 192'(3));
        expect_write(3'd5, 24'h000055);
        send_frame(3'd5, 24'h000055);
        check_all("addr5");
        check("addr5_waddr6", 192'(wa6), 192'(5));

        lock = 1'b1;
        send_frame(3'd0, 24'h13579B);
        lock = 1'b0;
        check_all("locked");
        expect_write(3'd0, 24'h13579B);
        send_frame(3'd0, 24'h13579B);
        check_all("unlocked");

        // reset after 10 bits, CSB held low, rest of the frame then clocked in
        bits = 64'({3'd2, 24'h654321});
        frame_begin();
        spi_bits(64'(bits[26:17]), 10);
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
        spi_bits(64'(bits[16:0]), 17);
        frame_end();
        model_reset();
        check_all("midrst");
        check("midrst_waddr", 192'(wa8), 192'(0));
        expect_write(3'd2, 24'h654321);
        send_frame(3'd2, 24'h654321);
        check_all("postrst");

        frame_begin(); frame_end();
        e_err8++; e_err6++;
        check_all("zerolen");

        // last SCLK rise and CSB rise land in the same sampled cycle
        bits = 64'({3'd7, 24'h0F0F0F});
        expect_write(3'd7, 24'h0F0F0F);
        frame_begin();
        spi_bits(64'(bits[26:1]), 26);
        mosi = bits[0];
        tick(HALF);
        sclk = 1'b1;
        csb  = 1'b1;
        tick(HALF);
        sclk = 1'b0;
        tick(12);
        check_all("samecycle");
        check("samecycle_waddr", 192'(wa8), 192'(7));

`ifdef REGBANK_SHADOW_EN
        commit = 1'b0;
        exp_q.push_back(3'd1); e_wr8++; e_wr6++;
        send_frame(3'd1, 24'h123456);
        check("shadow_hold8", 192'(regs8[1*DW +: DW]), 192'(m8[1]));
        check("shadow_hold6", 192'(regs6[1*DW +: DW]), 192'(m6[1]));
        commit = 1'b1;
        tick(1);
        commit = 1'b0;
        m8[1] = 24'h123456; m6[1] = 24'h123456;
        check_all("shadow_commit");
        exp_q.push_back(3'd4); e_wr8++; e_wr6++;
        frame_begin();
        spi_bits(64'({3'd4, 24'hC0FFEE}), 27);
        tick(HALF);
        csb = 1'b1;
        commit = 1'b1;
        tick(12);
        commit = 1'b0;
        m8[4] = 24'hC0FFEE; m6[4] = 24'hC0FFEE;
        check_all("shadow_coincide");
`endif

        tick(5);
        check("exp_q_drained", 192'(exp_q.size()), 192'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
